// File: rtl/skeleton_cpu.sv
// skeleton_cpu: single-cycle 32-bit load/store processor.
// Holds the PC, instruction ROM, 32x32 register file, ALU and data RAM.
// Everything runs off the rising edge of clock. A 2-bit divider marks the
// processor_clock phases, and one instruction executes per processor_clock
// period (4 clocks).
// Optional feature: SKELETON_OVF_STATUS_EN. When it is defined, a signed
// overflow on add/addi/sub suppresses the rd write and stores a status code
// in r30 instead.
module skeleton_cpu #(
   parameter string IMEM_INIT = "imem.hex",
   parameter int    MEM_DEPTH = 4096
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_clock,
   output logic        dmem_clock,
   output logic        processor_clock,
   output logic        regfile_clock,
   output logic [31:0] q,
   output logic [31:0] ALU_reg_imm,
   output logic [31:0] ALU_reg_test
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;

   logic [31:0] imem [MEM_DEPTH];
   logic [31:0] dmem [MEM_DEPTH];
   logic [31:0] regs [32];

   logic [1:0]  cnt;
   logic [11:0] pc;
   logic [31:0] dmem_q;

   logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
   logic [31:0] imm_sext, op_a, op_b, store_data;
   logic [31:0] sum, diff;
   logic [11:0] mem_addr;
   logic        wb_edge, dmem_we;
   logic        wr_en;
   logic [31:0] wr_data;
`ifdef SKELETON_OVF_STATUS_EN
   logic        ovf;
   logic [31:0] ovf_code;
`endif

   assign imem_clock      = clock;
   assign dmem_clock      = clock;
   assign processor_clock = ~cnt[1];
   assign regfile_clock   = processor_clock;

   // processor_clock rises on the edge that takes cnt from 3 to 0
   assign wb_edge = (cnt == 2'd3);

   assign opcode   = q[31:27];
   assign rd       = q[26:22];
   assign rs       = q[21:17];
   assign rt       = q[16:12];
   assign shamt    = q[11:7];
   assign aluop    = q[6:2];
   assign imm_sext = {{15{q[16]}}, q[16:0]};

   assign op_a       = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign store_data = (rd == 5'd0) ? 32'd0 : regs[rd];
   assign op_b       = (opcode == OP_RTYPE) ? ((rt == 5'd0) ? 32'd0 : regs[rt]) : imm_sext;

   assign ALU_reg_test = op_a;
   assign ALU_reg_imm  = op_b;

   assign sum      = op_a + op_b;
   assign diff     = op_a - op_b;
   assign mem_addr = op_a[11:0] + imm_sext[11:0];

   // Stores only while processor_clock is low, so a stale q during fetch never writes
   assign dmem_we = cnt[1] && (opcode == OP_SW);

   // Decode the current instruction into a register write
   always_comb begin
      wr_en   = 1'b0;
      wr_data = 32'd0;
`ifdef SKELETON_OVF_STATUS_EN
      ovf      = 1'b0;
      ovf_code = 32'd0;
`endif
      case (opcode)
         OP_RTYPE: begin
            case (aluop)
               ALU_ADD: begin
                  wr_en   = 1'b1;
                  wr_data = sum;
`ifdef SKELETON_OVF_STATUS_EN
                  ovf      = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
                  ovf_code = 32'd1;
`endif
               end
               ALU_SUB: begin
                  wr_en   = 1'b1;
                  wr_data = diff;
`ifdef SKELETON_OVF_STATUS_EN
                  ovf      = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
                  ovf_code = 32'd3;
`endif
               end
               ALU_AND: begin
                  wr_en   = 1'b1;
                  wr_data = op_a & op_b;
               end
               ALU_OR: begin
                  wr_en   = 1'b1;
                  wr_data = op_a | op_b;
               end
               ALU_SLL: begin
                  wr_en   = 1'b1;
                  wr_data = op_a << shamt;
               end
               ALU_SRA: begin
                  wr_en   = 1'b1;
                  wr_data = $signed(op_a) >>> shamt;
               end
               default: wr_en = 1'b0;
            endcase
         end
         OP_ADDI: begin
            wr_en   = 1'b1;
            wr_data = sum;
`ifdef SKELETON_OVF_STATUS_EN
            ovf      = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            ovf_code = 32'd2;
`endif
         end
         OP_LW: begin
            wr_en   = 1'b1;
            wr_data = dmem_q;
         end
         default: wr_en = 1'b0;
      endcase
   end

   // Divider, PC and instruction fetch
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= 2'd0;
         pc  <= 12'd0;
         q   <= 32'd0;
      end else begin
         cnt <= cnt + 2'd1;
         q   <= imem[pc];
         if (wb_edge) pc <= pc + 12'd1;
      end
   end

   // Register writeback on the processor_clock rise; r0 stays zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_edge) begin
`ifdef SKELETON_OVF_STATUS_EN
         if (ovf) regs[30] <= ovf_code;
         else if (wr_en && (rd != 5'd0)) regs[rd] <= wr_data;
`else
         if (wr_en && (rd != 5'd0)) regs[rd] <= wr_data;
`endif
      end
   end

   // Data RAM with registered read; contents survive reset
   always_ff @(posedge clock) begin
      if (dmem_we) dmem[mem_addr] <= store_data;
      dmem_q <= dmem[mem_addr];
   end

endmodule

// File: tb/tb_skeleton_cpu.sv
module tb_skeleton_cpu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_clock, dmem_clock, processor_clock, regfile_clock;
   logic [31:0] q, ALU_reg_imm, ALU_reg_test;

   always #5 clock = ~clock;

   skeleton_cpu #(.IMEM_INIT(""), .MEM_DEPTH(4096)) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_clock      (imem_clock),
      .dmem_clock      (dmem_clock),
      .processor_clock (processor_clock),
      .regfile_clock   (regfile_clock),
      .q               (q),
      .ALU_reg_imm     (ALU_reg_imm),
      .ALU_reg_test    (ALU_reg_test)
   );

`ifdef SKELETON_OVF_STATUS_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs[$];
   int   nerr = 0;
   int   nchecks = 0;
   logic prev_pclk = 1'b1;

   function automatic logic [31:0] rtype(input int rd, input int rs, input int rt,
                                         input int sh, input int aop);
      return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(aop), 2'b00};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rd, input int rs, input int imm);
      return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
   endfunction

   task automatic add_vec(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      v.instr = instr;
      v.exp_a = a;
      v.exp_b = b;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_pfall(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clock);
         if (prev_pclk === 1'b1 && processor_clock === 1'b0) ok = 1'b1;
         prev_pclk = processor_clock;
         if (ok) break;
      end
   endtask

   initial begin
      bit ok;
      int k;

      add_vec(itype(5, 1, 0, 5),        32'd0, 32'd5);
      add_vec(itype(5, 2, 0, 3),        32'd0, 32'd3);
      add_vec(rtype(3, 1, 2, 0, 0),     32'd5, 32'd3);
      add_vec(itype(5, 3, 3, 0),        32'd8, 32'd0);
      add_vec(rtype(4, 1, 2, 0, 1),     32'd5, 32'd3);
      add_vec(itype(5, 4, 4, 0),        32'd2, 32'd0);
      add_vec(rtype(6, 1, 2, 0, 2),     32'd5, 32'd3);
      add_vec(itype(5, 6, 6, 0),        32'd1, 32'd0);
      add_vec(rtype(7, 1, 2, 0, 3),     32'd5, 32'd3);
      add_vec(itype(5, 7, 7, 0),        32'd7, 32'd0);
      add_vec(rtype(8, 1, 0, 2, 4),     32'd5, 32'd0);
      add_vec(itype(5, 8, 8, 0),        32'd20, 32'd0);
      add_vec(rtype(9, 3, 0, 1, 5),     32'd8, 32'd0);
      add_vec(itype(5, 9, 9, 0),        32'd4, 32'd0);
      add_vec(itype(5, 10, 0, -8),      32'd0, 32'hFFFF_FFF8);
      add_vec(rtype(11, 10, 0, 2, 5),   32'hFFFF_FFF8, 32'd0);
      add_vec(itype(5, 0, 11, 0),       32'hFFFF_FFFE, 32'd0);
      add_vec(itype(5, 0, 0, 'h0FFFF),  32'd0, 32'h0000_FFFF);
      add_vec(itype(5, 0, 0, 'h10000),  32'd0, 32'hFFFF_0000);
      add_vec(itype(5, 20, 0, 1),       32'd0, 32'd1);
      add_vec(rtype(20, 20, 0, 30, 4),  32'd1, 32'd0);
      add_vec(rtype(21, 20, 20, 0, 0),  32'h4000_0000, 32'h4000_0000);
      add_vec(itype(5, 0, 30, 0),       OVF_EN ? 32'd1 : 32'd0, 32'd0);
      add_vec(itype(5, 0, 21, 0),       OVF_EN ? 32'd0 : 32'h8000_0000, 32'd0);
      add_vec(itype(5, 26, 20, -1),     32'h4000_0000, 32'hFFFF_FFFF);
      add_vec(rtype(22, 20, 26, 0, 0),  32'h4000_0000, 32'h3FFF_FFFF);
      add_vec(itype(5, 23, 22, 1),      32'h7FFF_FFFF, 32'd1);
      add_vec(itype(5, 0, 30, 0),       OVF_EN ? 32'd2 : 32'd0, 32'd0);
      add_vec(itype(5, 0, 23, 0),       OVF_EN ? 32'd0 : 32'h8000_0000, 32'd0);
      add_vec(itype(5, 23, 0, 1),       32'd0, 32'd1);
      add_vec(rtype(23, 23, 0, 31, 4),  32'd1, 32'd0);
      add_vec(itype(5, 24, 0, 1),       32'd0, 32'd1);
      add_vec(rtype(25, 23, 24, 0, 1),  32'h8000_0000, 32'd1);
      add_vec(itype(5, 0, 30, 0),       OVF_EN ? 32'd3 : 32'd0, 32'd0);
      add_vec(itype(5, 0, 25, 0),       OVF_EN ? 32'd0 : 32'h7FFF_FFFF, 32'd0);
      add_vec(itype(5, 5, 0, 345),      32'd0, 32'd345);
      add_vec(itype(5, 14, 0, 567),     32'd0, 32'd567);
      add_vec(itype(7, 5, 0, 1),        32'd0, 32'd1);
      add_vec(itype(7, 14, 0, 2),       32'd0, 32'd2);
      add_vec(itype(8, 12, 0, 1),       32'd0, 32'd1);
      add_vec(itype(8, 13, 0, 2),       32'd0, 32'd2);
      add_vec(itype(5, 0, 12, 0),       32'd345, 32'd0);
      add_vec(itype(5, 0, 13, 0),       32'd567, 32'd0);
      add_vec(itype(31, 1, 2, 7),       32'd3, 32'd7);
      add_vec(itype(5, 0, 1, 0),        32'd5, 32'd0);
      add_vec(rtype(1, 2, 2, 0, 6),     32'd3, 32'd3);
      add_vec(itype(5, 0, 1, 0),        32'd5, 32'd0);
      add_vec(itype(5, 0, 0, 9),        32'd0, 32'd9);
      add_vec(itype(5, 0, 0, 0),        32'd0, 32'd0);

      for (int i = 0; i < 4096; i++) dut.imem[i] = 32'd0;
      foreach (vecs[i]) dut.imem[i] = vecs[i].instr;

      // reset for two clocks, then check reset state mid-cycle
      repeat (2) @(negedge clock);
      check("rst_q", q, 32'd0);
      check("rst_pclk", {31'd0, processor_clock}, 32'd1);
      check("rst_rfclk", {31'd0, regfile_clock}, 32'd1);
      check("rst_A", ALU_reg_test, 32'd0);
      check("rst_B", ALU_reg_imm, 32'd0);
      reset = 1'b0;
      prev_pclk = 1'b1;

      foreach (vecs[i]) begin
         wait_pfall(ok);
         check($sformatf("v%0d_pfall", i), {31'd0, ok}, 32'd1);
         check($sformatf("v%0d_q", i), q, vecs[i].instr);
         check($sformatf("v%0d_A", i), ALU_reg_test, vecs[i].exp_a);
         check($sformatf("v%0d_B", i), ALU_reg_imm, vecs[i].exp_b);
      end

      // PC wraps from 4095 back to 0
      k = 0;
      for (int n = 1; n <= 4100; n++) begin
         wait_pfall(ok);
         if (!ok) break;
         if (q === vecs[0].instr) begin
            k = n;
            break;
         end
      end
      check("pc_wrap_falls", k, 32'd4048);
      check("wrap_A", ALU_reg_test, 32'd0);
      check("wrap_B", ALU_reg_imm, 32'd5);

      // reset mid-program, with a new program that reads old registers and old dmem
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_q", q, 32'd0);
      check("mid_rst_pclk", {31'd0, processor_clock}, 32'd1);
      check("mid_rst_A", ALU_reg_test, 32'd0);
      dut.imem[0] = itype(5, 0, 12, 0);
      dut.imem[1] = itype(5, 0, 9, 0);
      dut.imem[2] = itype(8, 15, 0, 1);
      dut.imem[3] = itype(5, 0, 15, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      prev_pclk = 1'b1;
      wait_pfall(ok);
      check("rr0_q", q, itype(5, 0, 12, 0));
      check("rr0_A_r12", ALU_reg_test, 32'd0);
      wait_pfall(ok);
      check("rr1_A_r9", ALU_reg_test, 32'd0);
      wait_pfall(ok);
      check("rr2_B", ALU_reg_imm, 32'd1);
      wait_pfall(ok);
      check("rr3_dmem_kept", ALU_reg_test, 32'd345);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
